// File: rtl/shr_seq.sv
// Sequential right shifter (logical or arithmetic), one bit per SHIFT cycle.
// Define SHR_SEQ_FASTPATH_EN to shift two bits per cycle while two or more remain.
module shr_seq #(
    parameter int n = 32,
    parameter int s = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] num,
    input  logic [s-1:0] shamt,
    input  logic         arith,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result
);

    // state | meaning
    // IDLE  | waiting for start; result holds the last value
    // SHIFT | working register shifting right, counter counting down
    // DONE  | publish working register to result and pulse done
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]   r_state;
    logic [n-1:0] r_work;
    logic [s-1:0] r_cnt;
    logic         r_fill;
    logic         r_busy;
    logic         r_done;
    logic [n-1:0] r_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_fill   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work  <= num;
                        r_cnt   <= shamt;
                        // Fill bit is resolved once here so SHIFT never looks at arith again.
                        r_fill  <= arith & num[n-1];
                        r_busy  <= 1'b1;
                        r_state <= (shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
`ifdef SHR_SEQ_FASTPATH_EN
                    if (r_cnt >= s'(2)) begin
                        r_work <= {{2{r_fill}}, r_work[n-1:2]};
                        r_cnt  <= r_cnt - s'(2);
                        if (r_cnt == s'(2)) begin
                            r_state <= DONE;
                        end
                    end else begin
                        r_work  <= {r_fill, r_work[n-1:1]};
                        r_cnt   <= r_cnt - s'(1);
                        r_state <= DONE;
                    end
`else
                    r_work <= {r_fill, r_work[n-1:1]};
                    r_cnt  <= r_cnt - s'(1);
                    if (r_cnt == s'(1)) begin
                        r_state <= DONE;
                    end
`endif
                end
                DONE: begin
                    r_done   <= 1'b1;
                    r_result <= r_work;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_shr_seq.sv
// Directed, table-driven bench for shr_seq: results, latency, busy-ignore and reset abort.
// Latency expectations follow SHR_SEQ_FASTPATH_EN when it is defined.
module tb_shr_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] num;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    shr_seq #(.n(32), .s(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .num    (num),
        .shamt  (shamt),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] num;
        logic [4:0]  shamt;
        logic        arith;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    function automatic int exp_lat(input int sh);
`ifdef SHR_SEQ_FASTPATH_EN
        return (sh + 1) / 2 + 1;
`else
        return sh + 1;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one operation; if inj > 0 a start with num=1, shamt=0 is pulsed
    // at that many cycles after acceptance. Inputs are scrambled after acceptance.
    task automatic run_op(input string name, input logic [31:0] a_num, input logic [4:0] a_sh,
                          input logic a_ar, input logic [31:0] a_exp, input int inj);
        int k;
        int pulses;
        @(negedge clk);
        num   = a_num;
        shamt = a_sh;
        arith = a_ar;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        num   = ~a_num;
        shamt = ~a_sh;
        arith = ~a_ar;
        k = 0;
        chk({name, " busy"}, {31'd0, busy}, 32'd1);
        while (!done && k < 64) begin
            start = (inj > 0 && k == inj);
            if (start) begin
                num   = 32'h1;
                shamt = 5'd0;
                arith = 1'b0;
            end
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, " done"}, {31'd0, done}, 32'd1);
        chk({name, " latency"}, k, exp_lat(int'(a_sh)));
        chk({name, " result"}, result, a_exp);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk({name, " extra done"}, pulses, 0);
        chk({name, " held"}, result, a_exp);
        chk({name, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{32'h80000010, 5'd4,  1'b0, 32'h08000001};
        vecs[1] = '{32'h80000010, 5'd4,  1'b1, 32'hF8000001};
        vecs[2] = '{32'h0000ABCD, 5'd0,  1'b0, 32'h0000ABCD};
        vecs[3] = '{32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001};
        vecs[4] = '{32'hFFFFFFFF, 5'd31, 1'b1, 32'hFFFFFFFF};
        vecs[5] = '{32'h12345678, 5'd8,  1'b1, 32'h00123456};
        vecs[6] = '{32'h87654321, 5'd1,  1'b1, 32'hC3B2A190};
        vecs[7] = '{32'h87654321, 5'd3,  1'b0, 32'h10ECA864};
        vecs[8] = '{32'hF0000000, 5'd5,  1'b1, 32'hFF800000};
        vecs[9] = '{32'hAAAAAAAA, 5'd16, 1'b0, 32'h0000AAAA};

        rst_n = 1'b0;
        start = 1'b1;
        num   = 32'hDEADBEEF;
        shamt = 5'd3;
        arith = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].num, vecs[i].shamt, vecs[i].arith, vecs[i].exp, 0);
        end

        run_op("busy ignore", 32'h80000010, 5'd4, 1'b0, 32'h08000001, 2);
        run_op("done ignore", 32'h87654321, 5'd3, 1'b0, 32'h10ECA864, exp_lat(3) - 1);

        // Abort mid-SHIFT; start held during reset must also be ignored.
        @(negedge clk);
        num   = 32'hFFFFFFFF;
        shamt = 5'd31;
        arith = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-abort busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        start = 1'b1;
        num   = 32'h1;
        shamt = 5'd0;
        @(negedge clk);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("abort no done", pulses, 0);
        chk("abort result held", result, 32'd0);

        run_op("post reset", 32'h80000010, 5'd4, 1'b1, 32'hF8000001, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shr_seq.md
SHR_SEQ -- requirements
Module: shr_seq

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter s, default 5, giving the shift-amount width; n <= 2**s is required.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a shift; sampled only in IDLE.
REQ-006 The block SHALL have port num, input, n bits: the operand, captured when start is accepted.
REQ-007 The block SHALL have port shamt, input, s bits: the right-shift amount, captured with num.
REQ-008 The block SHALL have port arith, input, 1 bit: 1 selects sign fill, 0 selects zero fill; captured with num.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-011 The block SHALL have port result, output, n bits: the shifted value, held until the next accepted start.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT and DONE; every output SHALL be registered.
REQ-013 In IDLE with start=1, the block SHALL load the working register from num, load the counter from shamt, latch arith, and go to SHIFT (shamt!=0) or DONE (shamt=0).
REQ-014 In SHIFT, each cycle SHALL shift the working register right by 1 bit, fill the MSB with 0 or with the latched sign bit, decrement the counter, and go to DONE when the counter reaches 0.
REQ-015 Bits shifted out at the LSB SHALL be discarded; no wrap-around.
REQ-016 The block SHALL assert done for exactly one cycle, in DONE, and SHALL present the final value on result in that same cycle; DONE SHALL always return to IDLE.
REQ-017 Latency SHALL be shamt+1 cycles from the start-accept edge to done high; shamt=0 gives done one cycle later with result=num.
REQ-018 The block SHALL ignore start while in SHIFT or DONE; num, shamt and arith changes after acceptance SHALL have no effect.
REQ-019 If shamt >= n, zero fill SHALL produce 0 and sign fill SHALL produce all bits equal to the captured num[n-1].
REQ-020 result SHALL keep its last value in IDLE and SHALL update only at the DONE transition.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL set the state to IDLE, busy=0, done=0, result=0, and clear the counter and working register.
REQ-022 Reset SHALL take priority over start and over an operation in progress; an aborted operation SHALL produce no done pulse.
REQ-023 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-024 The block SHALL support macro SHR_SEQ_FASTPATH_EN; when defined, SHIFT SHALL shift by 2 bits per cycle while the counter is >= 2 and by 1 bit when the counter is 1.
REQ-025 With SHR_SEQ_FASTPATH_EN defined, latency SHALL be ceil(shamt/2)+1 cycles; results SHALL be identical to the macro-undefined build.
REQ-026 Without SHR_SEQ_FASTPATH_EN, the block SHALL shift strictly 1 bit per cycle as in REQ-014.

Verification
REQ-027 Bench SHALL apply num=0x80000010, shamt=4, arith=0 and check result=0x08000001 with done high 5 cycles after acceptance (3 with fastpath).
REQ-028 Bench SHALL apply num=0x80000010, shamt=4, arith=1 and check result=0xF8000001.
REQ-029 Bench SHALL apply num=0x0000ABCD, shamt=0 and check done one cycle after acceptance with result=0x0000ABCD.
REQ-030 Bench SHALL apply num=0xFFFFFFFF, shamt=31, arith=0 and check result=0x00000001; with arith=1, result=0xFFFFFFFF.
REQ-031 Bench SHALL pulse start with num=0x1 while busy and check that it is ignored and the first operation's result is unchanged.
REQ-032 Bench SHALL drive rst_n=0 in mid-SHIFT and check that the next cycle has busy=0, done=0, result=0, and that no done pulse follows.
